// File: rtl/trig_scaler_pkg.sv
// Shared constants, FSM state type and word-count helper for the rate scaler.
// SCALER_MON_EN adds the monitor bank to the streamed word count.
package trig_scaler_pkg;

  localparam int NCHAN_DEF  = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int PERIOD_DEF = 250000000;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  function automatic int nwords(input int nchan);
`ifdef SCALER_MON_EN
    return 2 * nchan;
`else
    return nchan;
`endif
  endfunction

endpackage

// File: rtl/scaler_edge_counter.sv
// One scaler channel: input register, rising-edge detect, saturating counter.
// A clear coinciding with an edge loads 1 so the edge lands in the new period.
module scaler_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk250_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             in_q;
  logic             pulse;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pulse = in_i & ~in_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(pulse);
    end else if (pulse && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      in_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      in_q  <= in_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trig_scaler_sequencer.sv
// Gate timer, snapshot holding registers and valid/ready stream FSM.
// Define SCALER_MON_EN to add and stream the mon_scal_i counter bank.
module trig_scaler_sequencer
  import trig_scaler_pkg::*;
#(
  parameter int NCHAN         = NCHAN_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int PERIOD_CYCLES = PERIOD_DEF
) (
  input  logic                       clk250_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [NCHAN-1:0]           scal_i,
  input  logic [NCHAN-1:0]           mon_scal_i,
  output logic [CNT_W-1:0]           dat_o,
  output logic [$clog2(2*NCHAN)-1:0] chan_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i,
  output logic                       busy_o,
  output logic                       overrun_o,
  input  logic                       clr_overrun_i
);

  localparam int NW = nwords(NCHAN);
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = $clog2(2 * NCHAN);
  localparam int TW = $clog2(PERIOD_CYCLES + 1);

  logic [NW-1:0]    in_vec;
  logic [CNT_W-1:0] cnt    [NW];
  logic [CNT_W-1:0] hold_q [NW];
  logic [TW-1:0]    timer_q, timer_d;
  logic [IW-1:0]    idx_q, idx_d;
  state_e           state_q, state_d;
  logic             ovr_q, ovr_d;
  logic             tick, clr, capture, is_last;

  // Masking with enable keeps counters at 0 while the gate is off.
`ifdef SCALER_MON_EN
  assign in_vec = {mon_scal_i, scal_i} & {NW{enable_i}};
`else
  logic unused_mon;
  assign unused_mon = ^mon_scal_i;
  assign in_vec     = scal_i & {NW{enable_i}};
`endif

  assign tick = enable_i && (timer_q == TW'(PERIOD_CYCLES - 1));
  assign clr  = tick | ~enable_i;

  for (genvar g = 0; g < NW; g++) begin : g_cnt
    scaler_edge_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk250_i(clk250_i),
      .rst_i   (rst_i),
      .clr_i   (clr),
      .in_i    (in_vec[g]),
      .cnt_o   (cnt[g])
    );
  end

  assign timer_d   = clr ? '0 : timer_q + 1'b1;
  assign is_last   = (idx_q == IW'(NW - 1));
  assign overrun_o = ovr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    dat_o   = '0;
    chan_o  = CW'(idx_q);
    busy_o  = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        valid_o = 1'b1;
        last_o  = is_last;
        dat_o   = hold_q[idx_q];
        if (ready_i) begin
          if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // A new boundary wins over a same-cycle clear.
  always_comb begin
    ovr_d = ovr_q;
    if (tick && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (clr_overrun_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      ovr_q   <= ovr_d;
      if (capture) begin
        for (int i = 0; i < NW; i++) begin
          hold_q[i] <= cnt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_trig_scaler_sequencer.sv
// Directed bench for trig_scaler_sequencer: 4 channels, 100-cycle gate,
// plus a narrow-counter instance with a long gate for the saturation case.
module tb_trig_scaler_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  scal;
  logic [3:0]  mon;
  logic        rdy;
  logic        clr_ovr;
  logic [15:0] dat;
  logic [2:0]  chan;
  logic        valid, last, busy, ovr;

  logic        en_s;
  logic [3:0]  scal_s;
  logic        rdy_s;
  logic        clr_s;
  logic [7:0]  dat_s;
  logic [2:0]  chan_s;
  logic        valid_s, last_s, busy_s, ovr_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trig_scaler_sequencer #(
    .NCHAN(4), .CNT_W(16), .PERIOD_CYCLES(100)
  ) dut (
    .clk250_i(clk), .rst_i(rst), .enable_i(en),
    .scal_i(scal), .mon_scal_i(mon),
    .dat_o(dat), .chan_o(chan), .valid_o(valid), .last_o(last),
    .ready_i(rdy), .busy_o(busy), .overrun_o(ovr),
    .clr_overrun_i(clr_ovr)
  );

  trig_scaler_sequencer #(
    .NCHAN(4), .CNT_W(8), .PERIOD_CYCLES(1000)
  ) dut_s (
    .clk250_i(clk), .rst_i(rst), .enable_i(en_s),
    .scal_i(scal_s), .mon_scal_i(mon),
    .dat_o(dat_s), .chan_o(chan_s), .valid_o(valid_s), .last_o(last_s),
    .ready_i(rdy_s), .busy_o(busy_s), .overrun_o(ovr_s),
    .clr_overrun_i(clr_s)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int k = 0;
    while (!valid && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(valid), 32'd1);
  endtask

  // Called at the negedge where word 0 is visible, ready high.
  task automatic stream4(input string tag, input int w0, input int w1,
                         input int w2, input int w3);
    int e[4];
    e = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_dat"}, 32'(dat), 32'(e[i]));
      check({tag, "_chan"}, 32'(chan), 32'(i));
      check({tag, "_last"}, 32'(last), 32'(i == 3));
      @(negedge clk);
    end
    check({tag, "_end"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int k;
    int es[4];
    rst = 1'b1; en = 1'b0; scal = '0; mon = '0; rdy = 1'b1; clr_ovr = 1'b0;
    en_s = 1'b0; scal_s = '0; rdy_s = 1'b1; clr_s = 1'b0;
    skip(2);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_dat", 32'(dat), 32'd0);
    check("rst_chan", 32'(chan), 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // ch0 x5, ch2 x3, streamed back to back
    for (int i = 0; i < 5; i++) begin
      scal[0] = 1'b1;
      if (i < 3) scal[2] = 1'b1;
      @(negedge clk);
      scal[0] = 1'b0;
      scal[2] = 1'b0;
      @(negedge clk);
    end
    check("t1_idle_busy", 32'(busy), 32'd0);
    wait_valid("t1_wait", 200);
    scal[1] = 1'b1;
    stream4("t1", 5, 0, 3, 0);

    // ch1 held high: one count, then zero
    wait_valid("t2_wait", 200);
    stream4("t2a", 0, 1, 0, 0);
    wait_valid("t2b_wait", 200);
    scal[1] = 1'b0;
    stream4("t2b", 0, 0, 0, 0);

    // ch0 edge just before the tick, ch2 edge on the tick
    skip(94);
    scal[0] = 1'b1;
    @(negedge clk);
    scal[0] = 1'b0;
    scal[2] = 1'b1;
    check("t5_early", 32'(valid), 32'd0);
    @(negedge clk);
    scal[2] = 1'b0;
    check("t5_period", 32'(valid), 32'd1);
    stream4("t5a", 1, 0, 0, 0);

    // stalled readout across the next boundary
    wait_valid("t4_wait", 200);
    rdy = 1'b0;
    check("t4_dat0", 32'(dat), 32'd0);
    skip(10);
    for (int i = 0; i < 2; i++) begin
      scal[3] = 1'b1;
      @(negedge clk);
      scal[3] = 1'b0;
      @(negedge clk);
    end
    skip(85);
    check("t4_ovr_pre", 32'(ovr), 32'd0);
    @(negedge clk);
    check("t4_ovr_set", 32'(ovr), 32'd1);
    check("t4_hold_valid", 32'(valid), 32'd1);
    check("t4_hold_dat", 32'(dat), 32'd0);
    check("t4_hold_chan", 32'(chan), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    skip(50);
    rdy = 1'b1;
    stream4("t4", 0, 0, 1, 0);
    check("t4_ovr_sticky", 32'(ovr), 32'd1);
    for (int i = 0; i < 3; i++) begin
      scal[0] = 1'b1;
      @(negedge clk);
      scal[0] = 1'b0;
      @(negedge clk);
    end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("t4_ovr_clr", 32'(ovr), 32'd0);

    // async reset after word 1
    wait_valid("t6_wait", 100);
    check("t6_w0", 32'(dat), 32'd3);
    @(negedge clk);
    check("t6_w1_chan", 32'(chan), 32'd1);
    check("t6_w1_valid", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_chan", 32'(chan), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    scal[2] = 1'b1;
    @(negedge clk);
    scal[2] = 1'b0;
    @(negedge clk);
    check("t6_quiet", 32'(valid), 32'd0);
    wait_valid("t6_resume", 150);
    stream4("t6", 0, 0, 1, 0);

    // saturation on the 8-bit instance: 266 edges on ch3
    en_s = 1'b1;
    for (int i = 0; i < 266; i++) begin
      scal_s[3] = 1'b1;
      if (i < 3) scal_s[0] = 1'b1;
      @(negedge clk);
      scal_s = '0;
      @(negedge clk);
    end
    k = 0;
    while (!valid_s && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("t3_wait", 32'(valid_s), 32'd1);
    es = '{3, 0, 0, 255};
    for (int i = 0; i < 4; i++) begin
      check("t3_dat", 32'(dat_s), 32'(es[i]));
      check("t3_chan", 32'(chan_s), 32'(i));
      check("t3_last", 32'(last_s), 32'(i == 3));
      @(negedge clk);
    end
    check("t3_end", 32'(valid_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
